// File: rtl/tusca_pkg.sv
// Shared definitions for the DHT11 controller: state encoding, default timing
// and byte positions inside the 40-bit sensor frame (byte0 arrives first).
package tusca_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_LOW = 4'd1,
        ST_RELEASE   = 4'd2,
        ST_RESP_LOW  = 4'd3,
        ST_RESP_HIGH = 4'd4,
        ST_BIT_LOW   = 4'd5,
        ST_BIT_HIGH  = 4'd6,
        ST_CHECK     = 4'd7,
        ST_FIM       = 4'd8,
        ST_ERRO      = 4'd9
    } state_t;

    localparam int DEF_CYCLES_PER_US   = 50;
    localparam int DEF_START_LOW_US    = 18000;
    localparam int DEF_RESP_TIMEOUT_US = 100;
    localparam int DEF_BIT_THRESH_US   = 40;

    localparam int US_CNT_W   = 15;
    localparam int FRAME_BITS = 40;

    localparam int BYTE0_LSB = 32;
    localparam int BYTE1_LSB = 24;
    localparam int BYTE2_LSB = 16;
    localparam int BYTE3_LSB = 8;
    localparam int BYTE4_LSB = 0;

    function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] frame, input int lsb);
        return frame[lsb +: 8];
    endfunction

endpackage

// File: rtl/us_timer.sv
// Microsecond time base: prescaler emitting tick_us every CYCLES_PER_US cycles
// and a saturating microsecond counter, both restarted by clear.
module us_timer
    import tusca_pkg::*;
#(
    parameter int CYCLES_PER_US = DEF_CYCLES_PER_US
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    output logic [US_CNT_W-1:0] us_cnt,
    output logic                tick_us
);

    localparam int PW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CYCLES_PER_US - 1);

    logic [PW-1:0]       r_pre;
    logic [US_CNT_W-1:0] r_us_cnt;
    logic                w_tick;

    // tick depends on registers only, so clear (derived from next state) cannot loop back
    assign w_tick = (r_pre == PRE_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pre    <= '0;
            r_us_cnt <= '0;
        end else if (clear) begin
            r_pre    <= '0;
            r_us_cnt <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            if (w_tick && (r_us_cnt != '1)) begin
                r_us_cnt <= r_us_cnt + US_CNT_W'(1);
            end
        end
    end

    assign us_cnt  = r_us_cnt;
    assign tick_us = w_tick;

endmodule

// File: rtl/dht11_controller.sv
// DHT11 single-wire transaction sequencer: start pulse, response handshake,
// 40-bit read and checksum, reporting through a one-cycle pronto pulse.
module dht11_controller
    import tusca_pkg::*;
#(
    parameter int CYCLES_PER_US   = DEF_CYCLES_PER_US,
    parameter int START_LOW_US    = DEF_START_LOW_US,
    parameter int RESP_TIMEOUT_US = DEF_RESP_TIMEOUT_US,
    parameter int BIT_THRESH_US   = DEF_BIT_THRESH_US
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        dht_in,
    output logic        dht_oe,
    output logic        pronto,
    output logic        erro,
    output logic        ocupado,
    output logic [15:0] umidade,
    output logic [15:0] temperatura,
    output logic [3:0]  db_estado
);

    localparam logic [15:0] START_CNT   = 16'(START_LOW_US);
    localparam logic [15:0] TIMEOUT_CNT = 16'(RESP_TIMEOUT_US);
    localparam logic [15:0] THRESH_CNT  = 16'(BIT_THRESH_US);

    state_t                r_state, w_state_next;
    logic [1:0]            r_sync;
    logic                  r_sync_prev;
    logic [FRAME_BITS-1:0] r_shift;
    logic [5:0]            r_bit_cnt;
    logic                  r_erro;
    logic [15:0]           r_umidade, r_temperatura;

    logic                  w_line, w_fall, w_tick, w_clear, w_timeout, w_bit, w_sum_ok;
    logic [US_CNT_W-1:0]   w_us_cnt;
    logic [15:0]           w_elapsed;
    logic [7:0]            w_sum;
    logic                  w_oe, w_pronto, w_ocupado;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync      <= 2'b11;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync      <= {r_sync[0], dht_in};
            r_sync_prev <= r_sync[1];
        end
    end

    assign w_line = r_sync[1];
    assign w_fall = r_sync_prev & ~r_sync[1];

    assign w_clear = (w_state_next != r_state);

    us_timer #(
        .CYCLES_PER_US(CYCLES_PER_US)
    ) u_us_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_clear),
        .us_cnt (w_us_cnt),
        .tick_us(w_tick)
    );

    // Microseconds completed by the end of this cycle; makes phase widths exact.
    assign w_elapsed = {1'b0, w_us_cnt} + {15'd0, w_tick};
    assign w_timeout = (w_elapsed >= TIMEOUT_CNT);
    assign w_bit     = (w_elapsed >= THRESH_CNT);

    assign w_sum    = frame_byte(r_shift, BYTE0_LSB) + frame_byte(r_shift, BYTE1_LSB)
                    + frame_byte(r_shift, BYTE2_LSB) + frame_byte(r_shift, BYTE3_LSB);
    assign w_sum_ok = (w_sum == frame_byte(r_shift, BYTE4_LSB));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_oe         = 1'b0;
        w_pronto     = 1'b0;
        w_ocupado    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_ocupado = 1'b0;
                if (medir) w_state_next = ST_START_LOW;
            end
            ST_START_LOW: begin
                w_oe = 1'b1;
                if (w_elapsed >= START_CNT) w_state_next = ST_RELEASE;
            end
            // Falling edge, not level: the synchroniser still shows our own low pulse here.
            ST_RELEASE: begin
                if (w_fall)         w_state_next = ST_RESP_LOW;
                else if (w_timeout) w_state_next = ST_ERRO;
            end
            ST_RESP_LOW: begin
                if (w_line)         w_state_next = ST_RESP_HIGH;
                else if (w_timeout) w_state_next = ST_ERRO;
            end
            ST_RESP_HIGH: begin
                if (!w_line)        w_state_next = ST_BIT_LOW;
                else if (w_timeout) w_state_next = ST_ERRO;
            end
            ST_BIT_LOW: begin
                if (w_line)         w_state_next = ST_BIT_HIGH;
                else if (w_timeout) w_state_next = ST_ERRO;
            end
            ST_BIT_HIGH: begin
                if (w_fall)         w_state_next = (r_bit_cnt == 6'd39) ? ST_CHECK : ST_BIT_LOW;
                else if (w_timeout) w_state_next = ST_ERRO;
            end
            ST_CHECK: begin
                w_state_next = w_sum_ok ? ST_FIM : ST_ERRO;
            end
            ST_FIM, ST_ERRO: begin
                w_pronto     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_ocupado    = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_erro        <= 1'b0;
            r_umidade     <= '0;
            r_temperatura <= '0;
        end else begin
            if (r_state == ST_IDLE && medir) begin
                r_erro    <= 1'b0;
                r_bit_cnt <= '0;
            end
            if (r_state == ST_BIT_HIGH && w_fall) begin
                r_shift   <= {r_shift[FRAME_BITS-2:0], w_bit};
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end
            if (r_state == ST_CHECK && w_sum_ok) begin
                r_umidade     <= {frame_byte(r_shift, BYTE0_LSB), frame_byte(r_shift, BYTE1_LSB)};
                r_temperatura <= {frame_byte(r_shift, BYTE2_LSB), frame_byte(r_shift, BYTE3_LSB)};
            end
            if (r_state == ST_ERRO) begin
                r_erro <= 1'b1;
            end
        end
    end

    assign dht_oe      = w_oe;
    assign pronto      = w_pronto;
    assign ocupado     = w_ocupado;
    assign erro        = r_erro;
    assign umidade     = r_umidade;
    assign temperatura = r_temperatura;
    assign db_estado   = r_state;

endmodule

// File: tb/tb_dht11_controller.sv
// Directed bench for dht11_controller with a behavioural DHT11 sensor on the line.
module tb_dht11_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        medir = 1'b0;
    logic        sensor_lv = 1'b1;
    logic        dht_in;
    logic        dht_oe, pronto, erro, ocupado;
    logic [15:0] umidade, temperatura;
    logic [3:0]  db_estado;

    int total = 0;
    int bad = 0;
    int pronto_cnt = 0;
    int oe_cnt = 0;

    assign dht_in = dht_oe ? 1'b0 : sensor_lv;

    always #5 clock = ~clock;

    dht11_controller #(
        .CYCLES_PER_US  (1),
        .START_LOW_US   (20),
        .RESP_TIMEOUT_US(100),
        .BIT_THRESH_US  (40)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .medir      (medir),
        .dht_in     (dht_in),
        .dht_oe     (dht_oe),
        .pronto     (pronto),
        .erro       (erro),
        .ocupado    (ocupado),
        .umidade    (umidade),
        .temperatura(temperatura),
        .db_estado  (db_estado)
    );

    always @(negedge clock) begin
        if (pronto === 1'b1) pronto_cnt <= pronto_cnt + 1;
        if (dht_oe === 1'b1) oe_cnt <= oe_cnt + 1;
    end

    task automatic hold(input logic lv, input int n);
        sensor_lv = lv;
        repeat (n) @(negedge clock);
    endtask

    // Requests a measurement and plays the sensor side of the transaction.
    task automatic run_read(input logic [39:0] frame, input int hi0, input int hi1, input bit poke,
                            output int oe_cycles, output int pulses, output int poke_state);
        int p0, o0, n, w;
        p0 = pronto_cnt;
        o0 = oe_cnt;
        poke_state = -1;
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        n = 0;
        while (dht_oe === 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        hold(1'b1, 30);
        hold(1'b0, 80);
        hold(1'b1, 80);
        for (int i = 0; i < 40; i++) begin
            hold(1'b0, 50);
            w = frame[39-i] ? hi1 : hi0;
            if (poke && i == 10) begin
                hold(1'b1, 5);
                poke_state = int'(db_estado);
                medir = 1'b1;
                @(negedge clock);
                medir = 1'b0;
                hold(1'b1, w - 6);
            end else begin
                hold(1'b1, w);
            end
        end
        hold(1'b0, 50);
        sensor_lv = 1'b1;
        n = 0;
        while (pronto_cnt == p0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(negedge clock);
        pulses    = pronto_cnt - p0;
        oe_cycles = oe_cnt - o0;
    endtask

    task automatic test_reset;
        total++; if (dht_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", dht_oe); end
        total++; if (pronto !== 1'b0) begin bad++; $display("FAIL reset_pronto: got %b want 0", pronto); end
        total++; if (erro !== 1'b0) begin bad++; $display("FAIL reset_erro: got %b want 0", erro); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL reset_ocupado: got %b want 0", ocupado); end
        total++; if (umidade !== 16'h0000) begin bad++; $display("FAIL reset_umidade: got %h want 0000", umidade); end
        total++; if (temperatura !== 16'h0000) begin bad++; $display("FAIL reset_temp: got %h want 0000", temperatura); end
        total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", db_estado); end
        $display("reset: oe=%b ocupado=%b umidade=%h temperatura=%h", dht_oe, ocupado, umidade, temperatura);
    endtask

    task automatic test_nominal(input string tag);
        int oe_cycles, pulses, ps;
        run_read(40'h3500180552, 26, 70, 1'b0, oe_cycles, pulses, ps);
        total++; if (oe_cycles != 20) begin bad++; $display("FAIL %s_oe_width: got %0d want 20", tag, oe_cycles); end
        total++; if (pulses != 1) begin bad++; $display("FAIL %s_pronto_count: got %0d want 1", tag, pulses); end
        total++; if (umidade !== 16'h3500) begin bad++; $display("FAIL %s_umidade: got %h want 3500", tag, umidade); end
        total++; if (temperatura !== 16'h1805) begin bad++; $display("FAIL %s_temp: got %h want 1805", tag, temperatura); end
        total++; if (erro !== 1'b0) begin bad++; $display("FAIL %s_erro: got %b want 0", tag, erro); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL %s_ocupado: got %b want 0", tag, ocupado); end
        $display("%s: oe=%0d pronto=%0d umidade=%h temperatura=%h erro=%b", tag, oe_cycles, pulses, umidade, temperatura, erro);
    endtask

    task automatic test_checksum_fail;
        int oe_cycles, pulses, ps;
        run_read(40'h3500180553, 26, 70, 1'b0, oe_cycles, pulses, ps);
        total++; if (pulses != 1) begin bad++; $display("FAIL cksum_pronto_count: got %0d want 1", pulses); end
        total++; if (erro !== 1'b1) begin bad++; $display("FAIL cksum_erro: got %b want 1", erro); end
        total++; if (umidade !== 16'h3500) begin bad++; $display("FAIL cksum_umidade: got %h want 3500", umidade); end
        total++; if (temperatura !== 16'h1805) begin bad++; $display("FAIL cksum_temp: got %h want 1805", temperatura); end
        $display("checksum_fail: pronto=%0d erro=%b umidade=%h temperatura=%h", pulses, erro, umidade, temperatura);
    endtask

    task automatic test_bit_threshold;
        int oe_cycles, pulses, ps;
        // 0x41+0x0A+0x19+0x03 = 0x67; zeros last 39 us, ones last 40 us
        run_read(40'h410A190367, 39, 40, 1'b0, oe_cycles, pulses, ps);
        total++; if (umidade !== 16'h410A) begin bad++; $display("FAIL thresh_umidade: got %h want 410a", umidade); end
        total++; if (temperatura !== 16'h1903) begin bad++; $display("FAIL thresh_temp: got %h want 1903", temperatura); end
        total++; if (erro !== 1'b0) begin bad++; $display("FAIL thresh_erro: got %b want 0", erro); end
        $display("bit_threshold: umidade=%h temperatura=%h erro=%b", umidade, temperatura, erro);
    endtask

    task automatic test_busy_request;
        int oe_cycles, pulses, ps;
        run_read(40'h3500180552, 26, 70, 1'b1, oe_cycles, pulses, ps);
        total++; if (ps != 6) begin bad++; $display("FAIL busy_poke_state: got %0d want 6", ps); end
        total++; if (pulses != 1) begin bad++; $display("FAIL busy_pronto_count: got %0d want 1", pulses); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL busy_ocupado: got %b want 0", ocupado); end
        total++; if (umidade !== 16'h3500) begin bad++; $display("FAIL busy_umidade: got %h want 3500", umidade); end
        $display("busy_request: poke_state=%0d pronto=%0d ocupado=%b", ps, pulses, ocupado);
    endtask

    task automatic test_timeout;
        int n, m;
        sensor_lv = 1'b1;
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        n = 0;
        while (db_estado !== 4'd2 && n < 100) begin
            @(negedge clock);
            n++;
        end
        m = 0;
        while (db_estado !== 4'd9 && m < 500) begin
            @(negedge clock);
            m++;
        end
        total++; if (m != 100) begin bad++; $display("FAIL timeout_latency: got %0d want 100", m); end
        total++; if (pronto !== 1'b1) begin bad++; $display("FAIL timeout_pronto: got %b want 1", pronto); end
        @(negedge clock);
        total++; if (erro !== 1'b1) begin bad++; $display("FAIL timeout_erro: got %b want 1", erro); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL timeout_ocupado: got %b want 0", ocupado); end
        total++; if (pronto !== 1'b0) begin bad++; $display("FAIL timeout_pronto_width: got %b want 0", pronto); end
        total++; if (temperatura !== 16'h1805) begin bad++; $display("FAIL timeout_temp: got %h want 1805", temperatura); end
        $display("timeout: release_to_erro=%0d erro=%b ocupado=%b", m, erro, ocupado);
    endtask

    task automatic test_reset_mid;
        int n;
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        repeat (5) @(negedge clock);
        total++; if (dht_oe !== 1'b1) begin bad++; $display("FAIL midreset_pre_oe: got %b want 1", dht_oe); end
        #2 reset = 1'b1;
        #1;
        total++; if (dht_oe !== 1'b0) begin bad++; $display("FAIL midreset_oe: got %b want 0", dht_oe); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL midreset_ocupado: got %b want 0", ocupado); end
        total++; if (umidade !== 16'h0000) begin bad++; $display("FAIL midreset_umidade: got %h want 0000", umidade); end
        total++; if (temperatura !== 16'h0000) begin bad++; $display("FAIL midreset_temp: got %h want 0000", temperatura); end
        total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL midreset_state: got %0d want 0", db_estado); end
        n = 0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        $display("reset_mid: oe=%b ocupado=%b state=%0d", dht_oe, ocupado, db_estado);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        test_nominal("nominal");
        test_checksum_fail();
        test_bit_threshold();
        test_busy_request();
        test_timeout();
        test_reset_mid();
        test_nominal("after_reset");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dht11_controller.md
Name: dht11_controller

Overview:
- Sequences one complete DHT11 single-wire transaction when the top-level control FSM pulses `medir`.
- A transaction is: host start pulse, sensor response handshake, 40-bit data read, checksum verification.
- Presents humidity/temperature words and a one-cycle `pronto` completion pulse back to the control FSM.
- Sits between the system control FSM and the open-drain DHT11 data pin.

Parameters:
- CYCLES_PER_US, 50, clock cycles per microsecond (prescaler terminal count).
- START_LOW_US, 18000, duration the host holds the line low for the start pulse.
- RESP_TIMEOUT_US, 100, maximum width of any sensor low/high phase before an error is declared.
- BIT_THRESH_US, 40, measured high width ≥ this value decodes as '1'.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- medir  input  1  start request; sampled only in IDLE.
- dht_in  input  1  raw DHT11 line level (asynchronous to clock).
- dht_oe  output  1  1 = drive the line low; 0 = release (pull-up).
- pronto  output  1  one-cycle pulse at the end of every transaction (success or error).
- erro  output  1  last transaction failed (timeout or checksum); held until the next accepted `medir`.
- ocupado  output  1  high in every state except IDLE.
- umidade  output  16  integer byte in [15:8], decimal byte in [7:0].
- temperatura  output  16  integer byte in [15:8], decimal byte in [7:0].
- db_estado  output  4  current state encoding, for debug.

Behaviour:
- Reset (async):
  - state = IDLE; `dht_oe` = 0, so the line is released immediately, including mid-transaction.
  - `pronto`, `erro`, `ocupado` = 0; `umidade`, `temperatura` = 0.
  - Shift register and counters cleared.
- Input synchronisation:
  - `dht_in` passes through a 2-flop synchroniser before any use.
  - Edge detection operates on the synchronised value.
- Timing base:
  - A prescaler produces `tick_us` every CYCLES_PER_US cycles.
  - A 15-bit microsecond counter `us_cnt` clears on every state entry and increments on `tick_us`.
- State machine:
  - IDLE: `medir` = 1 → START_LOW; clear `erro` and the bit counter.
  - START_LOW: `dht_oe` = 1; `us_cnt` = START_LOW_US → RELEASE.
  - RELEASE: `dht_oe` = 0; sync line low → RESP_LOW; `us_cnt` = RESP_TIMEOUT_US → ERRO.
  - RESP_LOW: line high → RESP_HIGH; timeout → ERRO.
  - RESP_HIGH: line low → BIT_LOW; timeout → ERRO.
  - BIT_LOW: line high → BIT_HIGH; timeout → ERRO.
  - BIT_HIGH, falling edge:
    - Shift in bit = (`us_cnt` ≥ BIT_THRESH_US), MSB first, into a 40-bit register; increment the bit counter.
    - If this was the 40th bit → CHECK, otherwise → BIT_LOW.
  - BIT_HIGH, timeout → ERRO.
  - CHECK: byte0+byte1+byte2+byte3, mod 256.
    - Equal to byte4 → load `umidade` = {b0,b1} and `temperatura` = {b2,b3}, then → FIM.
    - Otherwise → ERRO.
  - FIM: `pronto` = 1 for one cycle → IDLE.
  - ERRO: `erro` set, `pronto` = 1 for one cycle → IDLE. Data outputs keep their previous values.
- Latency: `pronto` asserts exactly one cycle after the CHECK/timeout decision.
- Boundary conditions:
  - `medir` outside IDLE is ignored.
  - `medir` held high across FIM causes an immediate new transaction; this is legal.
  - Timeout and edge in the same cycle: the edge wins.
  - A high phase of exactly BIT_THRESH_US decodes as '1'.
  - `us_cnt` saturates at its maximum value and never wraps.
  - An unused state encoding → IDLE with `dht_oe` = 0.

Decomposition:
- Shared package (`tusca_pkg`):
  - State encoding constants (4-bit).
  - Default timing constants.
  - Byte-field index constants for the 40-bit frame.
- One natural sub-module: `us_timer`, containing the prescaler plus the saturating 15-bit microsecond counter.
  - Inputs: `clear`.
  - Outputs: `us_cnt`, `tick_us`.
- The synchroniser stays inline.

Test Plan:
- Simulation uses CYCLES_PER_US = 1 and START_LOW_US = 20 for speed.
- Nominal read:
  - Stimulus: sensor model answers with 80/80 µs response; frame 0x35,0x00,0x18,0x05,0x52.
  - Required: `dht_oe` high for exactly 20 µs; `pronto` single pulse; `umidade` = 0x3500, `temperatura` = 0x1805, `erro` = 0.
- Checksum fail:
  - Stimulus: same frame with last byte 0x53, following a successful read.
  - Required: `pronto` pulse, `erro` = 1; `umidade`/`temperatura` unchanged at 0x3500/0x1805.
- No-response timeout:
  - Stimulus: line held high after release.
  - Required: ERRO reached 100 µs after RELEASE entry; `pronto` pulses, `erro` = 1, `ocupado` returns to 0.
- Bit threshold:
  - Stimulus: high widths of 39 and 40 µs.
  - Required: decoded as 0 and 1 respectively.
- Reset mid-transaction:
  - Stimulus: assert reset during START_LOW.
  - Required: `dht_oe` = 0 immediately (asynchronous); all outputs at reset values; next `medir` starts cleanly.
- Busy request:
  - Stimulus: `medir` pulsed during BIT_HIGH.
  - Required: ignored; exactly one `pronto` for the transaction.
